// File: rtl/dmem_pkg.sv
// Shared types and defaults for the pipelined data memory.
package dmem_pkg;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } dmem_state_t;

  localparam int unsigned DMEM_DATA_W = 16;
  localparam int unsigned DMEM_ADDR_W = 16;
  localparam int unsigned DMEM_LAT    = 2;

  // Width of a counter able to hold the value lat.
  function automatic int unsigned cnt_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port storage array: registered read, optional byte-lane write.
module dmem_array #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter bit          ByteEn    = 1'b0,
  parameter string       INIT_FILE = "",
  parameter int unsigned BE_W      = (DATA_W >= 8) ? DATA_W / 8 : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  if (ByteEn) begin : g_byte_wr
    always_ff @(posedge clk_i) begin
      if (en_i && wr_i) begin
        for (int unsigned i = 0; i < BE_W; i++) begin
          if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end else begin : g_word_wr
    logic unused_be;
    assign unused_be = ^be_i;

    always_ff @(posedge clk_i) begin
      if (en_i && wr_i) mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data holds until the next read; writes never disturb it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (en_i && !wr_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_pipe.sv
// MEM-stage data memory with valid/ready handshake and LAT-cycle access latency.
// Optional byte-lane writes via the DMEM_BYTE_EN macro.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W    = DMEM_DATA_W,
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned LAT       = DMEM_LAT,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              re,
  input  logic              we,
  input  logic [DATA_W-1:0] wrt_data,
`ifdef DMEM_BYTE_EN
  input  logic [DATA_W/8-1:0] be,
`endif
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              rdy,
  output logic              err
);

  localparam int unsigned CntW = cnt_w(LAT);
  localparam int unsigned BeW  = (DATA_W >= 8) ? DATA_W / 8 : 1;

  if (LAT < 1 || LAT > 15) begin : g_lat_chk
    $error("data_mem_pipe: LAT must be within 1..15");
  end

  dmem_state_t       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              go_q, go_d;
  logic              accept;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BeW-1:0]    be_arr;
  logic              rd_vld_q;
  logic              err_q;

  assign accept = rdy & (re ^ we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  // go_d marks that the array performs the captured access at the next edge, so rdy
  // rises one cycle early and a new accept can coincide with the completion edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LAT == 1) begin
            go_d = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CntW'(LAT - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = IDLE;
          go_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy = (state_q == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_wr_q <= we;
      addr_q  <= addr;
      wdata_q <= wrt_data;
    end
  end

`ifdef DMEM_BYTE_EN
  logic [BeW-1:0] be_q;

  if (DATA_W % 8 != 0) begin : g_be_chk
    $error("data_mem_pipe: DATA_W must be a multiple of 8 with byte enables");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_q <= '0;
    end else if (accept) begin
      be_q <= be;
    end
  end

  assign be_arr = be_q;
  localparam bit ByteEn = 1'b1;
`else
  assign be_arr = '1;
  localparam bit ByteEn = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rd_vld_q <= go_q & ~op_wr_q;
      err_q    <= rdy & re & we;
    end
  end

  assign rd_vld = rd_vld_q;
  assign err    = err_q;

  dmem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ByteEn   (ByteEn),
    .INIT_FILE(INIT_FILE),
    .BE_W     (BeW)
  ) u_array (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (go_q),
    .wr_i   (op_wr_q),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .be_i   (be_arr),
    .rdata_o(rd_data)
  );

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: three instances (LAT=1,2,4) against a cycle-level reference model.
module tb_data_mem_pipe;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re_s   [N];
  logic        we_s   [N];
  logic [15:0] addr_s [N];
  logic [15:0] wd_s   [N];
  logic [15:0] rd_s   [N];
  logic        rv_s   [N];
  logic        rdy_s  [N];
  logic        err_s  [N];
`ifdef DMEM_BYTE_EN
  logic [1:0]  be_s   [N];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_pipe #(
      .DATA_W   (16),
      .ADDR_W   (16),
      .LAT      (1 << g),
      .INIT_FILE("")
    ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (addr_s[g]),
      .re      (re_s[g]),
      .we      (we_s[g]),
      .wrt_data(wd_s[g]),
`ifdef DMEM_BYTE_EN
      .be      (be_s[g]),
`endif
      .rd_data (rd_s[g]),
      .rd_vld  (rv_s[g]),
      .rdy     (rdy_s[g]),
      .err     (err_s[g])
    );
  end

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one outstanding access per instance, completing LAT edges after accept.
  int          cyc = 0;
  logic [15:0] mdl   [N][256];
  bit          p_vld [N];
  int          p_due [N];
  bit          p_wr  [N];
  logic [7:0]  p_a   [N];
  logic [15:0] p_d   [N];
  logic [1:0]  p_be  [N];
  bit          rdy_m [N];
  bit          rv_m  [N];
  bit          err_m [N];
  logic [15:0] rd_m  [N];

  task automatic model_step();
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        p_vld[i] = 1'b0; rdy_m[i] = 1'b1; rv_m[i] = 1'b0; err_m[i] = 1'b0; rd_m[i] = '0;
      end else begin
        rv_m[i]  = 1'b0;
        err_m[i] = 1'b0;
        if (p_vld[i] && p_due[i] == cyc) begin
          if (p_wr[i]) begin
            for (int l = 0; l < 2; l++)
              if (p_be[i][l]) mdl[i][p_a[i]][l*8 +: 8] = p_d[i][l*8 +: 8];
          end else begin
            rd_m[i] = mdl[i][p_a[i]];
            rv_m[i] = 1'b1;
          end
          p_vld[i] = 1'b0;
        end
        if (rdy_m[i] && (re_s[i] ^ we_s[i])) begin
          p_vld[i] = 1'b1;
          p_due[i] = cyc + (1 << i);
          p_wr[i]  = we_s[i];
          p_a[i]   = addr_s[i][7:0];
          p_d[i]   = wd_s[i];
`ifdef DMEM_BYTE_EN
          p_be[i]  = be_s[i];
`else
          p_be[i]  = 2'b11;
`endif
        end else if (rdy_m[i] && re_s[i] && we_s[i]) begin
          err_m[i] = 1'b1;
        end
        rdy_m[i] = !(p_vld[i] && cyc + 2 <= p_due[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      p_vld[i] = 1'b0; rdy_m[i] = 1'b1; rv_m[i] = 1'b0; err_m[i] = 1'b0; rd_m[i] = '0;
    end
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_on) begin
        for (int i = 0; i < N; i++) begin
          chk($sformatf("u%0d.rdy@%0d", i, cyc), 16'(rdy_s[i]), 16'(rdy_m[i]));
          chk($sformatf("u%0d.rd_vld@%0d", i, cyc), 16'(rv_s[i]), 16'(rv_m[i]));
          chk($sformatf("u%0d.err@%0d", i, cyc), 16'(err_s[i]), 16'(err_m[i]));
          chk($sformatf("u%0d.rd_data@%0d", i, cyc), rd_s[i], rd_m[i]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Present one request, hold it until the instance is ready, release after the accept edge.
  task automatic acc(input int idx, input bit wr, input logic [15:0] a, input logic [15:0] d,
                     input logic [1:0] b);
    int t;
    @(negedge clk);
    #1;
    re_s[idx] = !wr; we_s[idx] = wr; addr_s[idx] = a; wd_s[idx] = d;
`ifdef DMEM_BYTE_EN
    be_s[idx] = b;
`endif
    t = 0;
    while (!rdy_m[idx] && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk($sformatf("u%0d.accept_wait", idx), 16'(t < 50), 16'd1);
    @(posedge clk);
    #1;
    re_s[idx] = 1'b0; we_s[idx] = 1'b0;
  endtask

  // Conflicting re&&we request, presented for a single ready edge only.
  task automatic conflict(input int idx, input logic [15:0] a);
    int t;
    @(negedge clk);
    #1;
    t = 0;
    while (!rdy_m[idx] && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    re_s[idx] = 1'b1; we_s[idx] = 1'b1; addr_s[idx] = a; wd_s[idx] = 16'hFFFF;
    @(posedge clk);
    #1;
    re_s[idx] = 1'b0; we_s[idx] = 1'b0;
  endtask

  task automatic wait_rv(input int idx, output logic [15:0] v);
    int t;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rv_s[idx]) break;
    end
    chk($sformatf("u%0d.rd_vld_wait", idx), 16'(t < 20), 16'd1);
    v = rd_s[idx];
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] v;
  logic [15:0] vals [8];
  int          got, first, last, lowcnt, nerr, nrv;

  initial begin
    for (int i = 0; i < N; i++) begin
      re_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = '0; wd_s[i] = '0;
`ifdef DMEM_BYTE_EN
      be_s[i] = 2'b11;
`endif
    end

    tbl[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[2] = '{1'b1, 16'h0020, 16'h1234, 16'h0000};
    tbl[3] = '{1'b1, 16'h0030, 16'h5555, 16'h0000};
    tbl[4] = '{1'b0, 16'h0020, 16'h0000, 16'h1234};
    tbl[5] = '{1'b1, 16'h0010, 16'h0F0F, 16'h0000};
    tbl[6] = '{1'b0, 16'h0010, 16'h0000, 16'h0F0F};
    tbl[7] = '{1'b0, 16'h0030, 16'h0000, 16'h5555};

    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d.reset_rdy", i), 16'(rdy_s[i]), 16'd1);
      chk($sformatf("u%0d.reset_rd_vld", i), 16'(rv_s[i]), 16'd0);
      chk($sformatf("u%0d.reset_err", i), 16'(err_s[i]), 16'd0);
      chk($sformatf("u%0d.reset_rd_data", i), rd_s[i], 16'h0000);
    end
    #1;
    rst_n = 1'b1;
    chk_on = 1'b1;

    // Directed write/read table on the LAT=2 instance.
    for (int k = 0; k < 8; k++) begin
      acc(1, tbl[k].wr, tbl[k].a, tbl[k].d, 2'b11);
      if (!tbl[k].wr) begin
        wait_rv(1, v);
        chk($sformatf("tbl[%0d].rd_data", k), v, tbl[k].exp);
      end
    end

    // Conflict on 0x0020 (holds 0x1234): one err pulse, no read, memory untouched.
    conflict(1, 16'h0020);
    nerr = 0; nrv = 0;
    repeat (4) begin
      @(negedge clk);
      nerr += int'(err_s[1]);
      nrv  += int'(rv_s[1]);
    end
    chk("conflict.err_pulses", 16'(nerr), 16'd1);
    chk("conflict.rd_vld_pulses", 16'(nrv), 16'd0);
    acc(1, 1'b0, 16'h0020, 16'h0000, 2'b11);
    wait_rv(1, v);
    chk("conflict.readback", v, 16'h1234);

    // LAT=1 streaming: writes then back-to-back reads.
    for (int a = 0; a < 8; a++) acc(0, 1'b1, 16'(a), 16'(a * 3), 2'b11);
    got = 0; first = -1; last = -1; lowcnt = 0;
    fork
      begin : rd_stream
        for (int a = 0; a < 8; a++) acc(0, 1'b0, 16'(a), 16'h0000, 2'b11);
      end
      begin : rd_collect
        for (int k = 0; k < 30 && got < 8; k++) begin
          @(negedge clk);
          if (!rdy_s[0]) lowcnt++;
          if (rv_s[0]) begin
            vals[got] = rd_s[0];
            if (first < 0) first = k;
            last = k;
            got++;
          end
        end
      end
    join
    chk("stream.count", 16'(got), 16'd8);
    chk("stream.consecutive", 16'(last - first), 16'd7);
    chk("stream.rdy_low_cycles", 16'(lowcnt), 16'd0);
    for (int a = 0; a < 8; a++) chk($sformatf("stream.data[%0d]", a), vals[a], 16'(a * 3));

    // Reset two cycles into a LAT=4 write: the write must be discarded.
    acc(2, 1'b1, 16'h0030, 16'h5555, 2'b11);
    repeat (5) @(negedge clk);
    acc(2, 1'b1, 16'h0030, 16'hAAAA, 2'b11);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst.rdy", 16'(rdy_s[2]), 16'd1);
    #1;
    rst_n = 1'b1;
    acc(2, 1'b0, 16'h0030, 16'h0000, 2'b11);
    wait_rv(2, v);
    chk("midrst.readback", v, 16'h5555);

`ifdef DMEM_BYTE_EN
    acc(1, 1'b1, 16'h0040, 16'h1234, 2'b11);
    acc(1, 1'b1, 16'h0040, 16'hABCD, 2'b10);
    acc(1, 1'b0, 16'h0040, 16'h0000, 2'b11);
    wait_rv(1, v);
    chk("be.upper_lane", v, 16'hAB34);
    acc(1, 1'b1, 16'h0040, 16'hFFFF, 2'b00);
    acc(1, 1'b0, 16'h0040, 16'h0000, 2'b11);
    wait_rv(1, v);
    chk("be.no_lanes", v, 16'hAB34);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < N; i++) begin
      for (int a = 0; a < 16; a++) acc(i, 1'b1, 16'(a), 16'($urandom), 2'b11);
      for (int k = 0; k < 80; k++) begin
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) conflict(i, 16'($urandom_range(0, 15)));
        else acc(i, (r < 5), 16'($urandom_range(0, 15)), 16'($urandom),
                 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
    end

    repeat (8) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
